// File: rtl/pim_cmd_scheduler_if.sv
// Request/command bus of the PIM command scheduler: request push side,
// decoded command side and queue status.
interface pim_cmd_scheduler_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          req_valid;
   logic          req_ready;
   logic [25:0]   req_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    op;
   logic [2:0]    rank_id;
   logic [3:0]    bg_id;
   logic [14:0]   addr;
   logic [2:0]    rank1_id;
   logic [3:0]    bg1_id;
   logic [3:0]    addr1;
   logic [2:0]    rank2_id;
   logic [3:0]    bg2_id;
   logic [3:0]    addr2;
   logic          bgs;
   logic [1:0]    act_func;
   logic [CW-1:0] rd_count;
   logic [CW-1:0] wr_count;
   logic          drain_mode;

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, op, rank_id, bg_id, addr,
             rank1_id, bg1_id, addr1, rank2_id, bg2_id, addr2,
             bgs, act_func, rd_count, wr_count, drain_mode
   );

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, op, rank_id, bg_id, addr,
             rank1_id, bg1_id, addr1, rank2_id, bg2_id, addr2,
             bgs, act_func, rd_count, wr_count, drain_mode
   );
endinterface

// File: rtl/pim_cmd_scheduler.sv
// PIM command scheduler: separate read/write FIFOs, read-priority arbitration
// with write-drain watermarks and write anti-starvation, registered decode.
//
// state    | meaning
// RD_PRI   | reads win unless the starve counter has saturated
// WR_DRAIN | writes win until occupancy falls to the low watermark
module pim_cmd_scheduler #(
   parameter int DEPTH      = 8,
   parameter int WM_HI      = 6,
   parameter int WM_LO      = 2,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                reset,
   pim_cmd_scheduler_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {RD_PRI = 1'b0, WR_DRAIN = 1'b1} state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [2:0]  rank_id;
      logic [3:0]  bg_id;
      logic [14:0] addr;
      logic [2:0]  rank1_id;
      logic [3:0]  bg1_id;
      logic [3:0]  addr1;
      logic [2:0]  rank2_id;
      logic [3:0]  bg2_id;
      logic [3:0]  addr2;
      logic        bgs;
      logic [1:0]  act_func;
   } cmd_t;

   localparam cmd_t CMD_RST = {3'b111, 47'd0};

   logic [24:0]   rd_mem [DEPTH];
   logic [24:0]   wr_mem [DEPTH];
   logic [AW-1:0] rd_wp, rd_rp, wr_wp, wr_rp;
   logic [CW-1:0] rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
   logic          rd_full, wr_full, rd_empty, wr_empty;
   logic          push_rd, push_wr, grant_rd, grant_wr, advance;
   logic [SW-1:0] starve_q, starve_nxt;
   state_t        state_q, state_nxt;
   logic          out_valid_q;
   cmd_t          cmd_q, dec;
   logic [24:0]   sel_data;

   function automatic cmd_t decode(input logic [24:0] d);
      cmd_t c;
      c = '0;
      case (d[24:22])
         3'b000, 3'b001: begin
            c.op      = {2'b00, d[22]};
            c.rank_id = d[21:19];
            c.bg_id   = d[18:15];
            c.addr    = d[14:0];
         end
         3'b010, 3'b011: begin
            c.op      = {2'b00, d[22]};
            c.rank_id = d[21:19];
            c.addr    = d[18:4];
         end
         3'b100: begin
            c.op       = 3'b010;
            c.rank1_id = d[21:19];
            c.bg1_id   = d[18:15];
            c.addr1    = d[14:11];
            c.rank2_id = d[10:8];
            c.bg2_id   = d[7:4];
            c.addr2    = d[3:0];
         end
         3'b101: begin
            c.op      = 3'b011;
            c.rank_id = d[21:19];
         end
         3'b110: begin
            c.op       = 3'b100;
            c.rank_id  = d[21:19];
            c.bgs      = d[18];
            c.act_func = d[17:16];
         end
         default: begin
            c.op      = 3'b101;
            c.rank_id = d[21:19];
            c.bgs     = d[18];
         end
      endcase
      return c;
   endfunction

   assign rd_full       = (rd_cnt == CW'(DEPTH));
   assign wr_full       = (wr_cnt == CW'(DEPTH));
   assign rd_empty      = (rd_cnt == '0);
   assign wr_empty      = (wr_cnt == '0);
   assign bus.req_ready = bus.req_data[25] ? !rd_full : !wr_full;
   assign push_rd       = bus.req_valid && bus.req_ready && bus.req_data[25];
   assign push_wr       = bus.req_valid && bus.req_ready && !bus.req_data[25];
   assign advance       = !out_valid_q || bus.out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= RD_PRI;
         starve_q <= '0;
      end else begin
         state_q  <= state_nxt;
         starve_q <= starve_nxt;
      end
   end

   // Watermarks are judged on the counts as they will be after this edge.
   always_comb begin
      grant_rd   = 1'b0;
      grant_wr   = 1'b0;
      state_nxt  = state_q;
      starve_nxt = starve_q;
      if (advance) begin
         if (state_q == WR_DRAIN) begin
            if (!wr_empty)      grant_wr = 1'b1;
            else if (!rd_empty) grant_rd = 1'b1;
         end else begin
            if (starve_q == SW'(STARVE_MAX) && !wr_empty) grant_wr = 1'b1;
            else if (!rd_empty)                            grant_rd = 1'b1;
            else if (!wr_empty)                            grant_wr = 1'b1;
         end
      end
      rd_cnt_nxt = rd_cnt + CW'(push_rd) - CW'(grant_rd);
      wr_cnt_nxt = wr_cnt + CW'(push_wr) - CW'(grant_wr);
      case (state_q)
         RD_PRI:   if (wr_cnt_nxt >= CW'(WM_HI)) state_nxt = WR_DRAIN;
         WR_DRAIN: if (wr_cnt_nxt <= CW'(WM_LO)) state_nxt = RD_PRI;
         default:  state_nxt = RD_PRI;
      endcase
      if (grant_wr || wr_empty)
         starve_nxt = '0;
      else if (grant_rd && starve_q != SW'(STARVE_MAX))
         starve_nxt = starve_q + SW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_wp  <= '0;
         rd_rp  <= '0;
         wr_wp  <= '0;
         wr_rp  <= '0;
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (push_rd)  rd_wp <= rd_wp + AW'(1);
         if (grant_rd) rd_rp <= rd_rp + AW'(1);
         if (push_wr)  wr_wp <= wr_wp + AW'(1);
         if (grant_wr) wr_rp <= wr_rp + AW'(1);
         rd_cnt <= rd_cnt_nxt;
         wr_cnt <= wr_cnt_nxt;
      end
   end

   // Storage needs no reset; pointers and counts define what is valid.
   always_ff @(posedge clk) begin
      if (push_rd) rd_mem[rd_wp] <= bus.req_data[24:0];
      if (push_wr) wr_mem[wr_wp] <= bus.req_data[24:0];
   end

   assign sel_data = grant_wr ? wr_mem[wr_rp] : rd_mem[rd_rp];
   assign dec      = decode(sel_data);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         cmd_q       <= CMD_RST;
      end else if (advance) begin
         if (grant_rd || grant_wr) begin
            out_valid_q <= 1'b1;
            cmd_q       <= dec;
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.op         = cmd_q.op;
   assign bus.rank_id    = cmd_q.rank_id;
   assign bus.bg_id      = cmd_q.bg_id;
   assign bus.addr       = cmd_q.addr;
   assign bus.rank1_id   = cmd_q.rank1_id;
   assign bus.bg1_id     = cmd_q.bg1_id;
   assign bus.addr1      = cmd_q.addr1;
   assign bus.rank2_id   = cmd_q.rank2_id;
   assign bus.bg2_id     = cmd_q.bg2_id;
   assign bus.addr2      = cmd_q.addr2;
   assign bus.bgs        = cmd_q.bgs;
   assign bus.act_func   = cmd_q.act_func;
   assign bus.rd_count   = rd_cnt;
   assign bus.wr_count   = wr_cnt;
   assign bus.drain_mode = (state_q == WR_DRAIN);
endmodule

// File: tb/tb_pim_cmd_scheduler.sv
// Directed bench for pim_cmd_scheduler: decode vector table plus ordering,
// watermark, starvation and reset sequences.
module tb_pim_cmd_scheduler;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [14:0] cap_q[$];

   pim_cmd_scheduler_if #(.DEPTH(8)) bus ();

   pim_cmd_scheduler #(
      .DEPTH(8), .WM_HI(6), .WM_LO(2), .STARVE_MAX(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (reset && bus.out_valid && bus.out_ready) cap_q.push_back(bus.addr);

   typedef struct {
      logic [2:0]  opc;
      logic [21:0] opnd;
      logic [2:0]  e_op;
      logic [46:0] e_fld;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [46:0] mk(
      input logic [2:0] rk, input logic [3:0] bg, input logic [14:0] ad,
      input logic [2:0] rk1, input logic [3:0] bg1, input logic [3:0] ad1,
      input logic [2:0] rk2, input logic [3:0] bg2, input logic [3:0] ad2,
      input logic bs, input logic [1:0] af);
      return {rk, bg, ad, rk1, bg1, ad1, rk2, bg2, ad2, bs, af};
   endfunction

   function automatic logic [46:0] dut_fld();
      return {bus.rank_id, bus.bg_id, bus.addr, bus.rank1_id, bus.bg1_id, bus.addr1,
              bus.rank2_id, bus.bg2_id, bus.addr2, bus.bgs, bus.act_func};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rd, input logic [2:0] opc, input logic [21:0] opnd);
      bus.req_valid = 1'b1;
      bus.req_data  = {rd, opc, opnd};
      #1;
      check("push_ready", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_op"}, bus.op, 3'b111);
      check({tag, "_fields"}, dut_fld(), 0);
      check({tag, "_rd_count"}, bus.rd_count, 0);
      check({tag, "_wr_count"}, bus.wr_count, 0);
      check({tag, "_drain"}, bus.drain_mode, 0);
   endtask

   task automatic wait_cap(input int n, input string name);
      int cyc = 0;
      while (cap_q.size() < n && cyc < 300) begin
         tick();
         cyc++;
      end
      check(name, cap_q.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp3[10];
      int exp4[7];
      logic stale;

      vecs[0] = '{3'b000, {3'd2, 4'd5, 15'h1234}, 3'b000, mk(2, 5, 15'h1234, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[1] = '{3'b001, 22'h155555, 3'b001, mk(2, 4'hA, 15'h5555, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[2] = '{3'b010, 22'h2A5A5A, 3'b000, mk(5, 0, 15'h25A5, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[3] = '{3'b011, 22'h155555, 3'b001, mk(2, 0, 15'h5555, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[4] = '{3'b100, 22'h2A5A5A, 3'b010, mk(0, 0, 0, 5, 4, 4'hB, 2, 5, 4'hA, 0, 0)};
      vecs[5] = '{3'b101, 22'h3FFFFF, 3'b011, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
      vecs[6] = '{3'b110, 22'h360000, 3'b100, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2)};
      vecs[7] = '{3'b111, 22'h3C0000, 3'b101, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
      vecs[8] = '{3'b110, 22'h2A5A5A, 3'b100, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2)};

      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check_reset("rst");
      check("rst_req_ready", bus.req_ready, 1);
      reset = 1'b1;
      tick();

      // Decode table: one read at a time, downstream always ready.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         push(1'b1, vecs[i].opc, vecs[i].opnd);
         check($sformatf("v%0d_latency_valid", i), bus.out_valid, 0);
         check($sformatf("v%0d_latency_rdcnt", i), bus.rd_count, 1);
         tick();
         check($sformatf("v%0d_valid", i), bus.out_valid, 1);
         check($sformatf("v%0d_op", i), bus.op, vecs[i].e_op);
         check($sformatf("v%0d_fields", i), dut_fld(), vecs[i].e_fld);
         tick();
         check($sformatf("v%0d_idle", i), bus.out_valid, 0);
      end
      check("idle_hold_op", bus.op, vecs[8].e_op);
      check("idle_hold_fields", dut_fld(), vecs[8].e_fld);

      // Fill the read queue to full behind a held output, then drain in order.
      bus.out_ready = 1'b0;
      cap_q.delete();
      for (int i = 0; i < 9; i++) push(1'b1, 3'b000, 22'(i));
      check("full_rd_count", bus.rd_count, 8);
      check("full_out_valid", bus.out_valid, 1);
      bus.req_data = {1'b1, 25'd0};
      #1;
      check("full_rd_ready", bus.req_ready, 0);
      bus.req_data = {1'b0, 25'd0};
      #1;
      check("full_wr_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_data  = {1'b1, 3'b000, 22'd99};
      tick();
      bus.req_valid = 1'b0;
      check("full_blocked_count", bus.rd_count, 8);
      bus.out_ready = 1'b1;
      wait_cap(9, "fifo_drain_count");
      for (int i = 0; i < 9; i++)
         if (i < cap_q.size()) check($sformatf("fifo_order_%0d", i), cap_q[i], i);
      tick();
      check("fifo_end_valid", bus.out_valid, 0);
      check("fifo_end_rdcnt", bus.rd_count, 0);

      // Write-drain watermarks.
      bus.out_ready = 1'b0;
      tick();
      cap_q.delete();
      push(1'b1, 3'b000, 22'd100);
      for (int i = 0; i < 6; i++) push(1'b0, 3'b000, 22'(200 + i));
      check("wm_wr_count", bus.wr_count, 6);
      check("wm_drain_on", bus.drain_mode, 1);
      for (int i = 0; i < 3; i++) push(1'b1, 3'b000, 22'(300 + i));
      check("wm_rd_count", bus.rd_count, 3);
      exp3 = '{100, 200, 201, 202, 203, 300, 301, 302, 204, 205};
      bus.out_ready = 1'b1;
      wait_cap(10, "wm_drain_count");
      for (int i = 0; i < 10; i++)
         if (i < cap_q.size()) check($sformatf("wm_order_%0d", i), cap_q[i], exp3[i]);
      check("wm_drain_off", bus.drain_mode, 0);
      tick();

      // Write starvation: one write behind a stream of reads.
      bus.out_ready = 1'b0;
      tick();
      cap_q.delete();
      push(1'b1, 3'b000, 22'd400);
      push(1'b0, 3'b000, 22'd500);
      for (int i = 1; i <= 5; i++) push(1'b1, 3'b000, 22'(400 + i));
      exp4 = '{400, 401, 402, 403, 404, 500, 405};
      bus.out_ready = 1'b1;
      wait_cap(7, "starve_count");
      for (int i = 0; i < 7; i++)
         if (i < cap_q.size()) check($sformatf("starve_order_%0d", i), cap_q[i], exp4[i]);
      tick();

      // Reset mid-operation with a presented command and 3 queued entries.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b1, 3'b001, 22'h155555);
      check("mid_pre_rdcnt", bus.rd_count, 3);
      check("mid_pre_valid", bus.out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check_reset("mid_rst");
      tick();
      reset = 1'b1;
      bus.out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.out_valid) stale = 1'b1;
      end
      check("mid_no_stale", stale, 0);
      check("mid_post_rdcnt", bus.rd_count, 0);
      push(1'b1, 3'b000, 22'h77);
      tick();
      check("mid_new_valid", bus.out_valid, 1);
      check("mid_new_addr", bus.addr, 15'h77);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
